// File: rtl/eel_fetch_pkg.sv
// Shared types and defaults for the EEL fetch stage.
// Holds no logic; the fetch entry pairs a PC with the instruction word fetched from it.
package eel_fetch_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/eel_fetch_buf.sv
// Two-entry fetch output FIFO, head registered (push visible next cycle), flush clears all entries.
// Push into a full buffer is dropped; the fetch controller never issues far enough ahead for that to happen.
module eel_fetch_buf
  import eel_fetch_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_dat_i,
  input  logic         pop_i,
  output logic         head_vld_o,
  output fetch_entry_t head_dat_o,
  output logic [1:0]   occ_o
);

  logic [1:0]   occ_q, occ_d;
  fetch_entry_t ent0_q, ent0_d;
  fetch_entry_t ent1_q, ent1_d;
  logic         do_pop;

  assign do_pop = pop_i & (occ_q != 2'd0);

  // ent0 is always the head; a pop shifts ent1 down so order is preserved
  always_comb begin
    occ_d  = occ_q;
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    if (flush_i) begin
      occ_d = 2'd0;
    end else begin
      case ({push_i, do_pop})
        2'b01: begin
          ent0_d = ent1_q;
          occ_d  = occ_q - 2'd1;
        end
        2'b10: begin
          if (occ_q == 2'd0) begin
            ent0_d = push_dat_i;
            occ_d  = 2'd1;
          end else if (occ_q == 2'd1) begin
            ent1_d = push_dat_i;
            occ_d  = 2'd2;
          end
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            ent0_d = push_dat_i;
          end else begin
            ent0_d = ent1_q;
            ent1_d = push_dat_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q <= 2'd0;
    end else begin
      occ_q <= occ_d;
    end
    ent0_q <= ent0_d;
    ent1_q <= ent1_d;
  end

  assign head_vld_o = (occ_q != 2'd0);
  assign head_dat_o = ent0_q;
  assign occ_o      = occ_q;

endmodule

// File: rtl/eel_fetch.sv
// EEL fetch: PC register, IMEM issue (word reaches IF two cycles after issue) and 2-entry output buffer.
// Issue is throttled so stalled decode never overflows the buffer; EEL_FETCH_PERF_EN adds pop/stall counters.
module eel_fetch
  import eel_fetch_pkg::*;
#(
  parameter int              ADDR_DEPTH = 14,
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REDIRECT_VALID,
  input  logic [XLEN-1:0]       REDIRECT_PC,
  output logic                  IMEM_RDEN,
  output logic [ADDR_DEPTH-1:0] IMEM_ADDR,
  input  logic [INSTR_W-1:0]    IMEM_DATA,
  output logic                  IF_VALID,
  output logic [XLEN-1:0]       IF_PC,
  output logic [INSTR_W-1:0]    IF_INSTR,
  input  logic                  DEC_READY
`ifdef EEL_FETCH_PERF_EN
  ,
  output logic [31:0]           PERF_FETCHED,
  output logic [31:0]           PERF_STALL
`endif
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic            rsp_v_q, rsp_v_d;
  logic            pop;
  logic            issue;
  logic [1:0]      occ;
  logic [2:0]      fill;
  fetch_entry_t    head;
  fetch_entry_t    push_dat;

  assign pop = IF_VALID & DEC_READY;

  // Entries the buffer will hold once the word in flight lands; only issue if one slot stays free
  assign fill  = {1'b0, occ} + {2'b00, rsp_v_q} - {2'b00, pop};
  assign issue = !RST && !REDIRECT_VALID && (fill <= 3'd1);

  assign IMEM_RDEN = issue;
  assign IMEM_ADDR = pc_q[ADDR_DEPTH+1:2];

  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    rsp_v_d  = issue;
    if (REDIRECT_VALID) begin
      pc_d = REDIRECT_PC & 32'hFFFF_FFFC;
    end else if (issue) begin
      pc_d     = pc_q + 32'd4;
      rsp_pc_d = pc_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      rsp_v_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      rsp_v_q  <= rsp_v_d;
    end
  end

  assign push_dat = '{pc: rsp_pc_q, instr: IMEM_DATA};

  eel_fetch_buf u_buf (
    .clk_i      (CLK),
    .rst_i      (RST),
    .flush_i    (REDIRECT_VALID),
    .push_i     (rsp_v_q),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_vld_o (IF_VALID),
    .head_dat_o (head),
    .occ_o      (occ)
  );

  assign IF_PC    = head.pc;
  assign IF_INSTR = head.instr;

`ifdef EEL_FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_fetched_q <= 32'd0;
      perf_stall_q   <= 32'd0;
    end else begin
      perf_fetched_q <= perf_fetched_q + {31'd0, pop};
      perf_stall_q   <= perf_stall_q + {31'd0, IF_VALID & !DEC_READY};
    end
  end

  assign PERF_FETCHED = perf_fetched_q;
  assign PERF_STALL   = perf_stall_q;
`endif

endmodule

// File: tb/tb_eel_fetch.sv
// Directed bench for eel_fetch: IMEM model returns word n = n; expected {pc, instr} pairs queued per sequence.
module tb_eel_fetch;
  import eel_fetch_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REDIRECT_VALID = 1'b0;
  logic [31:0] REDIRECT_PC = 32'd0;
  logic        DEC_READY = 1'b0;
  logic        IMEM_RDEN;
  logic [13:0] IMEM_ADDR;
  logic [31:0] IMEM_DATA = 32'd0;
  logic        IF_VALID;
  logic [31:0] IF_PC;
  logic [31:0] IF_INSTR;
`ifdef EEL_FETCH_PERF_EN
  logic [31:0] PERF_FETCHED;
  logic [31:0] PERF_STALL;
`endif

  int tests = 0;
  int fails = 0;
  fetch_entry_t sb[$];
  logic        hold_prev = 1'b0;
  logic [31:0] prev_pc = 32'd0;
  logic [31:0] prev_instr = 32'd0;

  eel_fetch dut (
    .CLK            (CLK),
    .RST            (RST),
    .REDIRECT_VALID (REDIRECT_VALID),
    .REDIRECT_PC    (REDIRECT_PC),
    .IMEM_RDEN      (IMEM_RDEN),
    .IMEM_ADDR      (IMEM_ADDR),
    .IMEM_DATA      (IMEM_DATA),
    .IF_VALID       (IF_VALID),
    .IF_PC          (IF_PC),
    .IF_INSTR       (IF_INSTR),
    .DEC_READY      (DEC_READY)
`ifdef EEL_FETCH_PERF_EN
    ,
    .PERF_FETCHED   (PERF_FETCHED),
    .PERF_STALL     (PERF_STALL)
`endif
  );

  always #5 CLK = ~CLK;

  // Registered IMEM: word n holds value n, zero when not read
  always @(posedge CLK) IMEM_DATA <= IMEM_RDEN ? {18'd0, IMEM_ADDR} : 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_from(input logic [31:0] start, input int n);
    logic [31:0] p;
    p = start;
    for (int i = 0; i < n; i++) begin
      sb.push_back('{pc: p, instr: {18'd0, p[15:2]}});
      p = p + 32'd4;
    end
  endtask

  // One cycle: drive inputs, then check holds and any delivery happening at the coming edge
  task automatic cyc(input logic rdy, input logic redir, input logic [31:0] rpc, input logic rst);
    fetch_entry_t e;
    @(negedge CLK);
    DEC_READY      = rdy;
    REDIRECT_VALID = redir;
    REDIRECT_PC    = rpc;
    RST            = rst;
    #1;
    if (hold_prev) begin
      check("hold_pc", IF_PC, prev_pc);
      check("hold_instr", IF_INSTR, prev_instr);
    end
    if (IF_VALID && DEC_READY) begin
      tests++;
      assert (sb.size() > 0) else begin
        fails++;
        $error("FAIL extra_delivery observed_pc=%h expected=none", IF_PC);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("if_pc", IF_PC, e.pc);
        check("if_instr", IF_INSTR, e.instr);
      end
    end
    hold_prev  = IF_VALID && !DEC_READY && !redir && !rst;
    prev_pc    = IF_PC;
    prev_instr = IF_INSTR;
    if (redir || rst) sb.delete();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      cyc(1'b1, 1'b0, 32'd0, 1'b0);
      n++;
    end
    check("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 32'd0, 1'b1);
      check("rst_if_valid", IF_VALID, 32'd0);
      check("rst_rden", IMEM_RDEN, 32'd0);
    end
`ifdef EEL_FETCH_PERF_EN
    check("rst_perf_fetched", PERF_FETCHED, 32'd0);
    check("rst_perf_stall", PERF_STALL, 32'd0);
`endif

    // Release: stream, stall 5 cycles after the third delivery, resume
    expect_from(32'h0, 12);
    for (int c = 0; c < 30 && sb.size() != 0; c++) begin
      logic rdy;
      rdy = !(c >= 5 && c <= 9);
      cyc(rdy, 1'b0, 32'd0, 1'b0);
      if (c < 2) begin
        check("lat_if_valid", IF_VALID, 32'd0);
        check("lat_rden", IMEM_RDEN, 32'd1);
        check("lat_addr", IMEM_ADDR, c);
      end else begin
        check("stream_if_valid", IF_VALID, 32'd1);
      end
      if (c >= 5 && c <= 9) check("stall_rden", IMEM_RDEN, 32'd0);
    end
    check("seq1_empty", sb.size(), 32'd0);

    // Fill buffer, then redirect to a misaligned target
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'd0, 1'b0);
    check("full_rden", IMEM_RDEN, 32'd0);
    cyc(1'b0, 1'b1, 32'h0000_0103, 1'b0);
    check("redir_rden", IMEM_RDEN, 32'd0);
    expect_from(32'h100, 6);
    cyc(1'b1, 1'b0, 32'd0, 1'b0);
    check("redir_r1_valid", IF_VALID, 32'd0);
    check("redir_r1_rden", IMEM_RDEN, 32'd1);
    check("redir_r1_addr", IMEM_ADDR, 32'h40);
    cyc(1'b1, 1'b0, 32'd0, 1'b0);
    check("redir_r2_valid", IF_VALID, 32'd0);
    check("redir_r2_addr", IMEM_ADDR, 32'h41);
    cyc(1'b1, 1'b0, 32'd0, 1'b0);
    check("redir_r3_valid", IF_VALID, 32'd1);
    drain(20);

    // Redirect in the same cycle as a pop while a word is returning
    expect_from(32'h118, 1);
    cyc(1'b1, 1'b1, 32'h0000_0200, 1'b0);
    check("redir_pop_valid", IF_VALID, 32'd1);
    expect_from(32'h200, 4);
    cyc(1'b1, 1'b0, 32'd0, 1'b0);
    check("redir_pop_r1_valid", IF_VALID, 32'd0);
    drain(20);

    // IMEM address wrap at the top of the word space
    cyc(1'b0, 1'b1, 32'h0000_FFF8, 1'b0);
    expect_from(32'h0000_FFF8, 4);
    cyc(1'b1, 1'b0, 32'd0, 1'b0);
    check("wrap_addr0", IMEM_ADDR, 32'h3FFE);
    cyc(1'b1, 1'b0, 32'd0, 1'b0);
    check("wrap_addr1", IMEM_ADDR, 32'h3FFF);
    cyc(1'b1, 1'b0, 32'd0, 1'b0);
    check("wrap_addr2", IMEM_ADDR, 32'h0);
    drain(20);

    // Reset mid-stream drops everything and restarts at the reset PC
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    check("midrst_rden", IMEM_RDEN, 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    check("midrst_if_valid", IF_VALID, 32'd0);
`ifdef EEL_FETCH_PERF_EN
    check("midrst_perf_fetched", PERF_FETCHED, 32'd0);
    check("midrst_perf_stall", PERF_STALL, 32'd0);
`endif
    expect_from(32'h0, 3);
    cyc(1'b1, 1'b0, 32'd0, 1'b0);
    check("restart_rden", IMEM_RDEN, 32'd1);
    check("restart_addr", IMEM_ADDR, 32'h0);
    check("restart_if_valid", IF_VALID, 32'd0);
    drain(10);
    cyc(1'b0, 1'b0, 32'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/eel_fetch.md
# eel_fetch

Instruction fetch stage of the EEL core. Holds the program counter, drives word-address reads into the 64 KB instruction memory (one-cycle registered read; output is zero when read enable is low), and delivers {PC, instruction} pairs to decode over a valid/ready handshake. A 2-entry output buffer absorbs the memory's fixed latency so decode back-pressure never loses a returned word. Branch/jump redirects flush all in-flight work.

## Interface
- ADDR_DEPTH, 14: IMEM word-address width; must match the memory instance.
- RESET_PC, 32'h0000_0000: PC loaded on reset.

- CLK  in  1  rising-edge clock
- RST  in  1  synchronous, active-high reset
- REDIRECT_VALID  in  1  redirect request from execute
- REDIRECT_PC  in  32  redirect target; bits [1:0] ignored (treated as 0)
- IMEM_RDEN  out  1  read enable to IMEM
- IMEM_ADDR  out  ADDR_DEPTH  word address = PC[ADDR_DEPTH+1:2]
- IMEM_DATA  in  32  IMEM registered output
- IF_VALID  out  1  buffer head holds a valid instruction
- IF_PC  out  32  PC of head instruction
- IF_INSTR  out  32  head instruction
- DEC_READY  in  1  decode accepts head this cycle

## Operation
- State: pc (32), rsp_v (1, IMEM_DATA valid this cycle), rsp_pc (32), buffer occ (0..2) with entries {pc, instr}.
- pop = IF_VALID & DEC_READY. Issue condition: !RST & !REDIRECT_VALID & (occ − pop + rsp_v ≤ 1). IMEM_RDEN = issue (combinational on DEC_READY, by design).
- On issue: rsp_v ← 1, rsp_pc ← pc, pc ← pc + 4; otherwise rsp_v ← 0.
- When rsp_v=1: {rsp_pc, IMEM_DATA} written to buffer tail at the clock edge; pop and write in the same cycle allowed, order preserved.
- Redirect (REDIRECT_VALID=1): buffer cleared (occ ← 0), rsp_v ← 0 (returning word discarded), pc ← {REDIRECT_PC[31:2], 2'b00}, no issue that cycle; pop ignored.
- PC arithmetic modulo 2^32; IMEM_ADDR wraps naturally at 2^ADDR_DEPTH words.
- IF_PC/IF_INSTR are don't-care when IF_VALID=0 but must be held stable while IF_VALID=1 and DEC_READY=0.

## Timing
- Reset: pc=RESET_PC, occ=0, rsp_v=0; IF_VALID=0, IMEM_RDEN=0 while RST=1. RST beats REDIRECT_VALID.
- First issue in first cycle with RST=0; IF_VALID rises 2 cycles after issue cycle (issue t, IMEM_DATA valid t+1, IF_VALID t+2).
- Redirect sampled at edge of cycle r: IF_VALID=0 in r+1, target issued in r+1, target at IF in r+3.
- Sustained DEC_READY=1: one instruction per cycle, no bubbles.
- Reset mid-operation: all state dropped in one edge, no partial delivery.

## Configuration
- EEL_FETCH_PERF_EN defined: adds outputs PERF_FETCHED (32, count of pops) and PERF_STALL (32, cycles with IF_VALID & !DEC_READY); both cleared by RST, wrap at 2^32, unaffected by redirect.
- Undefined: ports and counters absent; functional behaviour identical.

## Structure
- Shared package eel_fetch_pkg: XLEN=32, INSTR_W=32, default RESET_PC, typedef fetch_entry_t {pc, instr}.
- Sub-module eel_fetch_buf: 2-entry FIFO of fetch_entry_t with push/pop/flush, occupancy output; fetch control, PC register and response tracking stay in eel_fetch.

## Test plan
- Reset release, DEC_READY=1, IMEM preloaded with word n = n: IF_VALID from cycle 2, IF_PC 0,4,8,… with IF_INSTR 0,1,2,… one per cycle.
- DEC_READY low 5 cycles after third delivery: IMEM_RDEN stops once occ=2; no instruction lost or duplicated; resume sequence continuous.
- REDIRECT_VALID with REDIRECT_PC=32'h0000_0103 while buffer full: IF_VALID=0 next cycle, then IF_PC=0x100 with word 64; pre-redirect words never appear.
- Redirect coincident with pop and with rsp_v=1: popped word not re-delivered, returning word dropped.
- PC at (2^ADDR_DEPTH−1)*4: next IMEM_ADDR=0, IF_PC continues to 2^(ADDR_DEPTH+2).
- RST asserted with occ=2 and rsp_v=1: next cycle IF_VALID=0, restart at RESET_PC; with EEL_FETCH_PERF_EN counters read 0.
